// File: rtl/dpd_lut_arbiter_if.sv
// Bus bundle for the DPD LUT arbiter: host port, adaptation-engine port and
// the actuator LUT configuration port.
interface dpd_lut_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  h_valid;
  logic                  h_we;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic                  h_ready;
  logic                  h_rvalid;
  logic [DATA_WIDTH-1:0] h_rdata;

  logic                  e_valid;
  logic                  e_we;
  logic                  e_last;
  logic [ADDR_WIDTH-1:0] e_addr;
  logic [DATA_WIDTH-1:0] e_wdata;
  logic                  e_ready;
  logic                  e_rvalid;
  logic [DATA_WIDTH-1:0] e_rdata;

  logic                  lut_enc;
  logic                  lut_wec;
  logic [ADDR_WIDTH-1:0] lut_addrc;
  logic [DATA_WIDTH-1:0] lut_dinc;
  logic [DATA_WIDTH-1:0] lut_doutc;
  logic                  lut_validc;

  // Requesters plus actuator model side
  modport master (
    output h_valid, h_we, h_addr, h_wdata,
    input  h_ready, h_rvalid, h_rdata,
    output e_valid, e_we, e_last, e_addr, e_wdata,
    input  e_ready, e_rvalid, e_rdata,
    input  lut_enc, lut_wec, lut_addrc, lut_dinc,
    output lut_doutc, lut_validc
  );

  // Arbiter side
  modport slave (
    input  h_valid, h_we, h_addr, h_wdata,
    output h_ready, h_rvalid, h_rdata,
    input  e_valid, e_we, e_last, e_addr, e_wdata,
    output e_ready, e_rvalid, e_rdata,
    output lut_enc, lut_wec, lut_addrc, lut_dinc,
    input  lut_doutc, lut_validc
  );
endinterface

// File: rtl/dpd_lut_arbiter.sv
// Arbitrates host single beats and engine bursts onto the actuator LUT config
// port; read returns are routed back to their owner in issue order via a tag FIFO.
module dpd_lut_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic             data_clk,
  input  logic             data_rstn,
  dpd_lut_arbiter_if.slave bus,
  input  logic             err_clr,
  output logic             err_orphan,
  output logic             busy
);
  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  typedef enum logic [1:0] {IDLE, HOST, ENG} state_t;

  state_t                state, state_nxt;
  logic                  rr_eng_last, rr_nxt;
  logic                  h_rdy, e_rdy;
  logic                  h_acc, e_acc;
  logic                  beat_acc, beat_we;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [DATA_WIDTH-1:0] beat_wdata;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [MAX_OUTST-1:0]  tag_mem;
  logic                  push, pop, pop_tag;

  // State and round-robin pointer register
  always_ff @(posedge data_clk or negedge data_rstn) begin
    if (!data_rstn) begin
      state       <= IDLE;
      rr_eng_last <= 1'b1;
    end else begin
      state       <= state_nxt;
      rr_eng_last <= rr_nxt;
    end
  end

  // Next-state: tie in IDLE goes to whoever was not granted last
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_eng_last;
    case (state)
      IDLE: begin
        if (bus.h_valid && (!bus.e_valid || rr_eng_last)) state_nxt = HOST;
        else if (bus.e_valid)                             state_nxt = ENG;
      end
      HOST:    if (h_acc) state_nxt = IDLE;
      ENG:     if (e_acc && bus.e_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if ((state == IDLE) && (state_nxt != IDLE)) rr_nxt = (state_nxt == ENG);
  end

  // Outputs from state: readiness (reads throttled by outstanding count) and busy
  always_comb begin
    h_rdy = 1'b0;
    e_rdy = 1'b0;
    case (state)
      HOST:    h_rdy = bus.h_we || (count < CNT_MAX);
      ENG:     e_rdy = bus.e_we || (count < CNT_MAX);
      default: ;
    endcase
    busy = (state != IDLE) || (count != '0);
  end

  assign bus.h_ready = h_rdy;
  assign bus.e_ready = e_rdy;
  assign h_acc       = bus.h_valid & h_rdy;
  assign e_acc       = bus.e_valid & e_rdy;

  // Select the accepted beat; at most one port can accept in a cycle
  always_comb begin
    beat_acc   = h_acc | e_acc;
    beat_we    = h_acc ? bus.h_we    : bus.e_we;
    beat_addr  = h_acc ? bus.h_addr  : bus.e_addr;
    beat_wdata = h_acc ? bus.h_wdata : bus.e_wdata;
  end

  assign push    = beat_acc & ~beat_we;
  assign pop     = bus.lut_validc & (count != '0);
  assign pop_tag = tag_mem[rd_ptr];

  // Registered LUT config command, one cycle after acceptance
  always_ff @(posedge data_clk or negedge data_rstn) begin
    if (!data_rstn) begin
      bus.lut_enc   <= 1'b0;
      bus.lut_wec   <= 1'b0;
      bus.lut_addrc <= '0;
      bus.lut_dinc  <= '0;
    end else if (beat_acc) begin
      bus.lut_enc   <= 1'b1;
      bus.lut_wec   <= beat_we;
      bus.lut_addrc <= beat_addr;
      bus.lut_dinc  <= beat_we ? beat_wdata : '0;
    end else begin
      bus.lut_enc   <= 1'b0;
      bus.lut_wec   <= 1'b0;
      bus.lut_addrc <= '0;
      bus.lut_dinc  <= '0;
    end
  end

  // Owner tag FIFO and outstanding-read counter (pointers wrap at power-of-2 depth)
  always_ff @(posedge data_clk or negedge data_rstn) begin
    if (!data_rstn) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= e_acc;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Route read data to the owning port; the idle port's rdata holds
  always_ff @(posedge data_clk or negedge data_rstn) begin
    if (!data_rstn) begin
      bus.h_rvalid <= 1'b0;
      bus.e_rvalid <= 1'b0;
      bus.h_rdata  <= '0;
      bus.e_rdata  <= '0;
    end else begin
      bus.h_rvalid <= pop & ~pop_tag;
      bus.e_rvalid <= pop & pop_tag;
      if (pop && !pop_tag) bus.h_rdata <= bus.lut_doutc;
      if (pop && pop_tag)  bus.e_rdata <= bus.lut_doutc;
    end
  end

  // Sticky orphan-return flag; a new orphan wins over a clear
  always_ff @(posedge data_clk or negedge data_rstn) begin
    if (!data_rstn)                           err_orphan <= 1'b0;
    else if (bus.lut_validc && count == '0)   err_orphan <= 1'b1;
    else if (err_clr)                         err_orphan <= 1'b0;
  end
endmodule

// File: doc/dpd_lut_arbiter.md
DPD_LUT_ARBITER -- requirements
Module: dpd_lut_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 10, LUT address width; DATA_WIDTH, default 32, LUT entry width; MAX_OUTST, default 4, maximum outstanding LUT reads (power of 2, 2..16).
REQ-002 data_clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-003 data_rstn  in  1  reset, asynchronous assert, active-low.
REQ-004 h_valid, h_we  in  1 each  host beat request and write flag (single-beat transactions).
REQ-005 h_addr  in  ADDR_WIDTH  host address; h_wdata  in  DATA_WIDTH  host write data.
REQ-006 h_ready  out  1  host beat accept; h_rvalid  out  1, h_rdata  out  DATA_WIDTH  host read return.
REQ-007 e_valid, e_we, e_last  in  1 each  adaptation-engine beat request, write flag, last beat of burst.
REQ-008 e_addr  in  ADDR_WIDTH; e_wdata  in  DATA_WIDTH  engine address/data.
REQ-009 e_ready  out  1; e_rvalid  out  1; e_rdata  out  DATA_WIDTH  engine accept and read return.
REQ-010 lut_enc, lut_wec  out  1 each; lut_addrc  out  ADDR_WIDTH; lut_dinc  out  DATA_WIDTH  actuator LUT config port.
REQ-011 lut_doutc  in  DATA_WIDTH; lut_validc  in  1  actuator LUT read return.
REQ-012 busy  out  1  state not IDLE or outstanding reads > 0.
REQ-013 err_orphan  out  1  sticky; err_clr  in  1  synchronous clear.

Function
REQ-014 FSM states SHALL be IDLE, HOST, ENG; reset state IDLE.
REQ-015 IDLE: h_valid only -> HOST; e_valid only -> ENG; both -> the requester not granted last (rr pointer, reset value = engine-last, so host wins first tie); neither -> IDLE.
REQ-016 rr pointer SHALL update on every IDLE->HOST or IDLE->ENG transition.
REQ-017 h_ready SHALL be high only in HOST and only when h_we=1 or outstanding count < MAX_OUTST; e_ready likewise in ENG; both SHALL be 0 in IDLE.
REQ-018 HOST: one accepted beat (h_valid & h_ready) -> IDLE next cycle.
REQ-019 ENG: lock held across beats; accepted beat with e_last=1 -> IDLE; e_valid low in ENG SHALL hold ENG (no timeout).
REQ-020 Each accepted beat SHALL drive lut_enc=1, lut_wec=we, lut_addrc, lut_dinc (0 for reads) registered, exactly one cycle after acceptance; otherwise lut_enc=0, lut_wec=0, lut_addrc=0, lut_dinc=0.
REQ-021 Each accepted read SHALL push an owner tag (0 host, 1 engine) into a MAX_OUTST-deep tag FIFO and increment the outstanding count.
REQ-022 Each lut_validc with count>0 SHALL pop the tag and decrement count; push and pop in the same cycle SHALL leave count unchanged.
REQ-023 Read return SHALL appear one cycle after lut_validc on the owner's rvalid/rdata (rdata = lut_doutc); the other port's rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-024 Returns SHALL be delivered in issue order; no dependency on actuator read latency.
REQ-025 lut_validc with count=0 SHALL set err_orphan, discard data, assert no rvalid; err_clr and a new orphan in the same cycle SHALL leave err_orphan=1.
REQ-026 Tag FIFO pointers SHALL wrap modulo MAX_OUTST; count SHALL never exceed MAX_OUTST (enforced by REQ-017).
REQ-027 busy SHALL be combinational from state and count.

Reset
REQ-028 data_rstn low SHALL immediately clear state to IDLE, rr pointer to engine-last, count, tag FIFO pointers, err_orphan, and all outputs (h_ready, e_ready, h_rvalid, e_rvalid, rdata, lut_*, busy) to 0.
REQ-029 Reset mid-burst SHALL abandon the burst; reads outstanding at reset SHALL be forgotten, and their late lut_validc SHALL raise err_orphan.

Verification
REQ-030 Host write addr 0x005 data 0xCAFE_0001 -> h_ready in HOST, next cycle lut_enc=1, lut_wec=1, lut_addrc=0x005, lut_dinc=0xCAFE_0001 for one cycle, FSM back to IDLE.
REQ-031 h_valid and e_valid together after reset, twice -> first grant HOST, second ENG; engine 4-beat write burst uninterrupted while h_valid held high.
REQ-032 Engine 5 reads, actuator returning validc 3 cycles later -> e_ready drops after 4th accept until first validc; 5 e_rvalid pulses in order, h_rvalid never high.
REQ-033 Interleaved host read addr 0x010 then engine read addr 0x020, returns 0xAAAA, 0xBBBB -> h_rdata=0xAAAA, then e_rdata=0xBBBB.
REQ-034 lut_validc with nothing outstanding -> err_orphan=1, no rvalid; err_clr -> 0 next cycle.
REQ-035 Reset asserted mid-burst with 2 reads outstanding -> all outputs 0 immediately, busy=0; subsequent validc sets err_orphan.
